branch_cmp_pipe: RTL
====================

// Module: branch_cmp_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle branch comparator.
//  Takes two operands and a RISC-V branch funct3, and resolves the branch outcome
//  (taken/less/equal/illegal) over PIPE_STAGES registered stages.
//  Uses a valid/ready handshake with full backpressure and a synchronous flush.
//  Sits between the EX operand muxes and the PC-redirect logic for wide/high-fmax builds.
// PARAMETERS
//  DATA_W       32  operand width; even, >=4
//  PIPE_STAGES  1   1: full compare in stage 1; 2: half-width compares in S1, combine in S2
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       sync kill of all in-flight entries (pipeline redirect)
//  in_valid   in   1       operand beat valid
//  in_ready   out  1       unit can accept a beat this cycle
//  a          in   DATA_W  operand rs1
//  b          in   DATA_W  operand rs2
//  funct3     in   3       branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_taken  out  1       branch condition true
//  out_less   out  1       a<b (signed if funct3[1]==0, else unsigned)
//  out_equal  out  1       a==b
//  out_illgl  out  1       funct3 is 010 or 011
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valids=0.
//    out_valid=0, out_taken=0, out_less=0, out_equal=0, out_illgl=0.
//  - Handshake: a beat transfers when valid&ready on the same edge.
//    out_* fields hold stable while out_valid=1 and out_ready=0.
//  - Each stage is a 1-entry register with valid bit v_k.
//    Last stage: advances when !v_last | out_ready.
//    Stage k: advances when !v_k | (stage k+1 advances).
//    in_ready = stage-1 advance condition (combinational from out_ready; no skid).
//  - Latency is exactly PIPE_STAGES cycles from accept to out_valid when unstalled.
//    Throughput is 1 beat/cycle.
//  - Compare arithmetic, with H=DATA_W/2 and sgn = ~funct3[1]:
//    - S1 computes:
//      - hi_eq = a[W-1:H]==b[W-1:H]
//      - hi_lt = sgn ? signed(a_hi)<signed(b_hi) : a_hi<b_hi
//      - lo_eq = a[H-1:0]==b[H-1:0]
//      - lo_lt = unsigned lo compare
//    - equal = hi_eq & lo_eq
//    - less = hi_lt | (hi_eq & lo_lt)
//    - PIPE_STAGES=1: S1 combines and registers the final fields.
//      PIPE_STAGES=2: S1 registers hi_eq/hi_lt/lo_eq/lo_lt and funct3; S2 combines.
//  - Taken decode:
//    - BEQ = equal
//    - BNE = ~equal
//    - BLT/BLTU = less
//    - BGE/BGEU = ~less
//    - 010/011: taken=0, illgl=1; less/equal still reported (unsigned per funct3[1]=1)
//  - Flush:
//    - Next edge clears every v_k; beats in flight are dropped, never presented.
//    - A beat offered with in_valid in the flush cycle is also dropped.
//    - Flush has priority over accept and over out_ready.
//    - in_ready stays per the normal rule; an accepted+flushed beat is lost by design.
//  - out_taken/out_less/out_equal/out_illgl: each goes to 0 with out_valid when its entry leaves and nothing refills.
//  - Boundary cases:
//    - a==b: less=0, equal=1
//    - signed: 0x8000_0000 < 0x7FFF_FFFF; unsigned: reversed
//    - hi halves equal: result decided by lo_lt alone
//  - rst_n asserted mid-stream: all results discarded immediately (async); in_ready=1 after release.
// TESTING
//  1. W=32,P=1: a=5,b=5,BEQ -> out_valid 1 cycle after accept, taken=1, equal=1, less=0.
//  2. W=32,P=2: a=0x8000_0000,b=1, BLT -> taken=1; same operands BLTU -> taken=0.
//     Latency must be 2 cycles.
//  3. P=2: back-to-back 4 beats, out_ready held 0 for 3 cycles, then 1.
//     -> no loss or duplication, order kept, in_ready=0 while both stages full.
//  4. P=2: flush while both stages valid and in_valid=1.
//     -> out_valid=0 next cycle; next accepted beat is the only result seen.
//  5. funct3=011, a=2,b=1 -> taken=0, illgl=1, less=0, equal=0.
//  6. Reset asserted asynchronously with out_valid=1 -> out_valid=0 before next edge.
//     W=64,P=2: a=0x1_0000_0000, b=0x0_FFFF_FFFF, BGEU -> taken=1.

Source files
------------

// File: rtl/branch_cmp_pipe.sv
// Pipelined RISC-V branch comparator: resolves taken/less/equal/illegal over
// PIPE_STAGES registered stages behind a valid/ready handshake with flush.
module branch_cmp_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        funct3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_taken,
    output logic              out_less,
    output logic              out_equal,
    output logic              out_illgl
);

    localparam int unsigned H = DATA_W / 2;

    // Half-width compare results plus the branch type they belong to
    typedef struct packed {
        logic       hi_eq;
        logic       hi_lt;
        logic       lo_eq;
        logic       lo_lt;
        logic [2:0] f3;
    } raw_t;

    // Final resolved branch fields
    typedef struct packed {
        logic taken;
        logic less;
        logic equal;
        logic illgl;
    } res_t;

    // Merge half compares into equal/less and decode the branch condition
    function automatic res_t combine(input raw_t r);
        res_t o;
        o.equal = r.hi_eq & r.lo_eq;
        o.less  = r.hi_lt | (r.hi_eq & r.lo_lt);
        o.illgl = (r.f3[2:1] == 2'b01);
        case (r.f3)
            3'b000:         o.taken = o.equal;
            3'b001:         o.taken = ~o.equal;
            3'b100, 3'b110: o.taken = o.less;
            3'b101, 3'b111: o.taken = ~o.less;
            default:        o.taken = 1'b0;
        endcase
        return o;
    endfunction

    logic [H-1:0] a_hi, b_hi, a_lo, b_lo;
    raw_t         raw_c;

    // Stage-1 half-width compares; only the high half honours signedness
    always_comb begin
        a_hi        = a[DATA_W-1:H];
        b_hi        = b[DATA_W-1:H];
        a_lo        = a[H-1:0];
        b_lo        = b[H-1:0];
        raw_c.f3    = funct3;
        raw_c.hi_eq = (a_hi == b_hi);
        raw_c.hi_lt = funct3[1] ? (a_hi < b_hi) : ($signed(a_hi) < $signed(b_hi));
        raw_c.lo_eq = (a_lo == b_lo);
        raw_c.lo_lt = (a_lo < b_lo);
    end

    if (PIPE_STAGES == 1) begin : g_p1
        logic v_q, v_d;
        res_t res_q, res_d;
        logic adv;

        assign adv = ~v_q | out_ready;

        // Single stage: combine and capture; emptied slot reads as zero
        always_comb begin
            v_d   = v_q;
            res_d = res_q;
            if (flush) begin
                v_d   = 1'b0;
                res_d = '0;
            end else if (adv) begin
                v_d   = in_valid;
                res_d = in_valid ? combine(raw_c) : '0;
            end
        end

        // Stage register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                res_q <= '0;
            end else begin
                v_q   <= v_d;
                res_q <= res_d;
            end
        end

        assign in_ready  = adv;
        assign out_valid = v_q;
        assign out_taken = res_q.taken;
        assign out_less  = res_q.less;
        assign out_equal = res_q.equal;
        assign out_illgl = res_q.illgl;
    end else begin : g_p2
        logic v1_q, v1_d, v2_q, v2_d;
        raw_t raw_q, raw_d;
        res_t res_q, res_d;
        logic adv1, adv2;

        assign adv2 = ~v2_q | out_ready;
        assign adv1 = ~v1_q | adv2;

        // S1 holds half compares, S2 holds combined result; flush empties both
        always_comb begin
            v1_d  = v1_q;
            raw_d = raw_q;
            v2_d  = v2_q;
            res_d = res_q;
            if (flush) begin
                v1_d  = 1'b0;
                raw_d = '0;
                v2_d  = 1'b0;
                res_d = '0;
            end else begin
                if (adv1) begin
                    v1_d  = in_valid;
                    raw_d = in_valid ? raw_c : '0;
                end
                if (adv2) begin
                    v2_d  = v1_q;
                    res_d = v1_q ? combine(raw_q) : '0;
                end
            end
        end

        // Stage registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q  <= 1'b0;
                raw_q <= '0;
                v2_q  <= 1'b0;
                res_q <= '0;
            end else begin
                v1_q  <= v1_d;
                raw_q <= raw_d;
                v2_q  <= v2_d;
                res_q <= res_d;
            end
        end

        assign in_ready  = adv1;
        assign out_valid = v2_q;
        assign out_taken = res_q.taken;
        assign out_less  = res_q.less;
        assign out_equal = res_q.equal;
        assign out_illgl = res_q.illgl;
    end

endmodule
